// File: rtl/sram_arbiter.sv
// Shares one single-port SRAM between an instruction-fetch port and a data port.
// Each access occupies WAIT_CYCLES SRAM cycles, then the winner gets a one-cycle ready.
module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 3,
  parameter int unsigned ADDR_W      = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  output logic              freeze,
  input  logic              mem_rd_en,
  input  logic              mem_wr_en,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_ready,
  output logic              mem_freeze,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  output logic              sram_we,
  output logic              sram_oe,
  input  logic [31:0]       sram_rdata
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic             sel_mem;
  logic             is_write;
  logic             last_mem;
  logic             mem_req;
  logic             pick_mem;
  logic             pick_wr;
  logic             grant;
  logic             finish;

  // Byte-offset bits and address bits above the SRAM range carry no information.
  logic unused_addr;
  assign unused_addr = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                         mem_addr[31:ADDR_W+2], mem_addr[1:0]};

  assign mem_req    = mem_rd_en | mem_wr_en;
  assign freeze     = if_req & ~if_ready;
  assign mem_freeze = mem_req & ~mem_ready;

  // Round-robin on contention: data wins unless it was the last port served.
  assign pick_mem = mem_req & (~if_req | ~last_mem);
  assign pick_wr  = pick_mem & mem_wr_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    grant      = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (if_req | mem_req) begin
          grant      = 1'b1;
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == CNT_W'(WAIT_CYCLES - 1)) begin
          finish     = 1'b1;
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Latched request, SRAM strobes, captured read data and ready pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      sel_mem    <= 1'b0;
      is_write   <= 1'b0;
      last_mem   <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_we    <= 1'b0;
      sram_oe    <= 1'b0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
      if_ready   <= 1'b0;
      mem_ready  <= 1'b0;
    end else begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      if (grant) begin
        cnt        <= '0;
        sel_mem    <= pick_mem;
        is_write   <= pick_wr;
        sram_addr  <= pick_mem ? mem_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];
        sram_wdata <= pick_wr ? mem_wdata : 32'h0;
        sram_we    <= pick_wr;
        sram_oe    <= ~pick_wr;
      end else if (state == ACCESS) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (finish) begin
        sram_we <= 1'b0;
        sram_oe <= 1'b0;
        if (sel_mem) begin
          mem_ready <= 1'b1;
          if (!is_write) mem_rdata <= sram_rdata;
        end else begin
          if_ready <= 1'b1;
          if_rdata <= sram_rdata;
        end
      end
      if (state == DONE) last_mem <= sel_mem;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: behavioural SRAM, scoreboard of expected
// completions (port, data, cycle) checked as each ready pulse appears.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_rd_en, mem_wr_en;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [31:0] if_rdata, mem_rdata, sram_wdata, sram_rdata;
  logic        if_ready, mem_ready, freeze, mem_freeze, sram_we, sram_oe;
  logic [16:0] sram_addr;

  logic        if1_req;
  logic [31:0] if1_addr, if1_rdata, mem1_rdata, sram1_wdata, sram1_rdata;
  logic        if1_ready, freeze1, mem1_ready, mem1_freeze, sram1_we, sram1_oe;
  logic [16:0] sram1_addr;

  logic [31:0] sram_mem [0:255];
  logic        load_en;
  logic [7:0]  load_addr;
  logic [31:0] load_data;

  typedef struct {
    bit          port_mem;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Word-addressed SRAM model shared by both instances (only dut writes).
  always @(posedge clk) begin
    if (load_en)      sram_mem[load_addr] <= load_data;
    else if (sram_we) sram_mem[sram_addr[7:0]] <= sram_wdata;
  end
  assign sram_rdata  = sram_mem[sram_addr[7:0]];
  assign sram1_rdata = sram_mem[sram1_addr[7:0]];

  sram_arbiter #(.WAIT_CYCLES(3), .ADDR_W(17)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .freeze(freeze),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_freeze(mem_freeze),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_we(sram_we),
    .sram_oe(sram_oe), .sram_rdata(sram_rdata)
  );

  sram_arbiter #(.WAIT_CYCLES(1), .ADDR_W(17)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if1_req), .if_addr(if1_addr), .if_rdata(if1_rdata), .if_ready(if1_ready),
    .freeze(freeze1),
    .mem_rd_en(1'b0), .mem_wr_en(1'b0), .mem_addr(32'h0),
    .mem_wdata(32'h0), .mem_rdata(mem1_rdata), .mem_ready(mem1_ready),
    .mem_freeze(mem1_freeze),
    .sram_addr(sram1_addr), .sram_wdata(sram1_wdata), .sram_we(sram1_we),
    .sram_oe(sram1_oe), .sram_rdata(sram1_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Advance until a ready pulse, then compare it against the scoreboard head.
  task automatic wait_ready(input string tag);
    exp_t e;
    bit   got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (if_ready | mem_ready) got = 1'b1;
    end
    check({tag, "_timeout"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({tag, "_port"}, 32'(mem_ready), 32'(e.port_mem));
        check({tag, "_excl"}, 32'(if_ready & mem_ready), 32'd0);
        check({tag, "_data"}, e.port_mem ? mem_rdata : if_rdata, e.data);
        check({tag, "_cycle"}, 32'(cyc), 32'(e.cyc));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t0;
    exp_t e;
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    mem_rd_en = 1'b0; mem_wr_en = 1'b0; mem_addr = '0; mem_wdata = '0;
    if1_req = 1'b0; if1_addr = '0;
    load_en = 1'b1; load_addr = 8'h04; load_data = 32'hE3A01005;
    tick();
    load_en = 1'b0;
    tick();

    // Reset state
    check("rst_we",     32'(sram_we), 0);
    check("rst_oe",     32'(sram_oe), 0);
    check("rst_addr",   32'(sram_addr), 0);
    check("rst_wdata",  sram_wdata, 0);
    check("rst_ifrd",   if_rdata, 0);
    check("rst_memrd",  mem_rdata, 0);
    check("rst_ready",  32'({if_ready, mem_ready}), 0);
    rst = 1'b0;
    tick();

    // Single fetch at 0x10
    t0 = cyc;
    if_req = 1'b1; if_addr = 32'h10;
    #1 check("f_freeze0", 32'(freeze), 1);
    sb.push_back('{1'b0, 32'hE3A01005, t0 + 4});
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("f_addr",   32'(sram_addr), 32'h4);
      check("f_oe",     32'(sram_oe), 1);
      check("f_we",     32'(sram_we), 0);
      check("f_freeze", 32'(freeze), 1);
    end
    wait_ready("fetch");
    check("f_freeze_rdy", 32'(freeze), 0);
    if_req = 1'b0;
    tick();
    check("f_pulse", 32'(if_ready), 0);
    check("f_hold",  if_rdata, 32'hE3A01005);

    // Single data write to 0x104
    t0 = cyc;
    mem_wr_en = 1'b1; mem_addr = 32'h104; mem_wdata = 32'hDEADBEEF;
    #1 check("w_mfreeze0", 32'(mem_freeze), 1);
    sb.push_back('{1'b1, 32'h0, t0 + 4});
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("w_we",    32'(sram_we), 1);
      check("w_oe",    32'(sram_oe), 0);
      check("w_addr",  32'(sram_addr), 32'h41);
      check("w_wdata", sram_wdata, 32'hDEADBEEF);
    end
    wait_ready("write");
    mem_wr_en = 1'b0;
    tick();
    check("w_sram", sram_mem[8'h41], 32'hDEADBEEF);

    // Read and write together behaves as a write
    t0 = cyc;
    mem_rd_en = 1'b1; mem_wr_en = 1'b1; mem_addr = 32'h203; mem_wdata = 32'h12345678;
    sb.push_back('{1'b1, 32'h0, t0 + 4});
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("rw_oe",   32'(sram_oe), 0);
      check("rw_we",   32'(sram_we), 1);
      check("rw_addr", 32'(sram_addr), 32'h80);
    end
    wait_ready("rdwr");
    mem_rd_en = 1'b0; mem_wr_en = 1'b0;
    tick();
    check("rw_sram",  sram_mem[8'h80], 32'h12345678);
    check("rw_rdata", mem_rdata, 32'h0);

    // Contention from fresh reset: data, fetch, data, fetch
    rst = 1'b1;
    tick();
    rst = 1'b0;
    t0 = cyc;
    if_req = 1'b1; if_addr = 32'h10;
    mem_rd_en = 1'b1; mem_addr = 32'h104;
    sb.push_back('{1'b1, 32'hDEADBEEF, t0 + 4});
    sb.push_back('{1'b0, 32'hE3A01005, t0 + 9});
    sb.push_back('{1'b1, 32'hDEADBEEF, t0 + 14});
    sb.push_back('{1'b0, 32'hE3A01005, t0 + 19});
    for (int k = 0; k < 4; k++) wait_ready("rr");
    if_req = 1'b0; mem_rd_en = 1'b0;
    tick();

    // Reset during the second ACCESS cycle of a write
    mem_wr_en = 1'b1; mem_addr = 32'h300; mem_wdata = 32'hCAFEF00D;
    tick();
    check("ra_we1", 32'(sram_we), 1);
    tick();
    check("ra_we2", 32'(sram_we), 1);
    rst = 1'b1;
    #1 check("ra_we_drop", 32'(sram_we), 0);
    tick();
    check("ra_noready", 32'(mem_ready), 0);
    rst = 1'b0;
    t0 = cyc;
    sb.push_back('{1'b1, 32'h0, t0 + 4});
    wait_ready("rst_abort");
    mem_wr_en = 1'b0;
    tick();
    check("ra_sram", sram_mem[8'hC0], 32'hCAFEF00D);

    // WAIT_CYCLES=1 fetch
    t0 = cyc;
    if1_req = 1'b1; if1_addr = 32'h12;
    sb.push_back('{1'b0, 32'hE3A01005, t0 + 2});
    tick();
    check("w1_oe",    32'(sram1_oe), 1);
    check("w1_ready", 32'(if1_ready), 0);
    tick();
    check("w1_ready2", 32'(if1_ready), 1);
    check("w1_sb", 32'(sb.size()), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("w1_data",  if1_rdata, e.data);
      check("w1_cycle", 32'(cyc), 32'(e.cyc));
    end
    if1_req = 1'b0;
    tick();
    check("w1_pulse", 32'(if1_ready), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
